// File: rtl/alu_arb_pkg.sv
// Shared definitions for the ALU share arbiter: op codes, FSM states, flag bit positions.
package alu_arb_pkg;

  localparam logic [2:0] ALU_PASS_B = 3'b000;
  localparam logic [2:0] ALU_ADD    = 3'b010;
  localparam logic [2:0] ALU_SUB    = 3'b011;
  localparam logic [2:0] ALU_AND    = 3'b100;
  localparam logic [2:0] ALU_OR     = 3'b101;
  localparam logic [2:0] ALU_XOR    = 3'b110;

  localparam int FLAG_NEG  = 3;
  localparam int FLAG_ZERO = 2;
  localparam int FLAG_OVF  = 1;
  localparam int FLAG_COUT = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  function automatic logic ctrl_is_legal(input logic [2:0] ctrl);
    logic legal;
    case (ctrl)
      ALU_PASS_B, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR: legal = 1'b1;
      default:                                                legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/alu_arb_pick.sv
// Two-requester grant logic. Define ALU_ARB_FIXED_PRIO_EN for fixed priority
// (requester 0 wins ties, no history); otherwise round-robin on ties.
module alu_arb_pick
  import alu_arb_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [1:0] req_valid_i,
  input  logic       accept_i,
  output logic [1:0] grant_o
);

`ifdef ALU_ARB_FIXED_PRIO_EN

  // Requester 0 always has priority.
  always_comb begin
    grant_o = {req_valid_i[1] & ~req_valid_i[0], req_valid_i[0]};
  end

`else

  // Remembers which requester won last; 1 after reset so requester 0 wins the first tie.
  logic last_q;
  logic last_d;

  // Last-grant register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

  // Update history only when a grant is actually taken.
  always_comb begin
    if (accept_i) begin
      last_d = grant_o[1];
    end else begin
      last_d = last_q;
    end
  end

  // Round-robin on ties.
  always_comb begin
    case (req_valid_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = last_q ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
  end

`endif

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external ALU between two requesters: accept, hold operands for a settle
// window, capture result/flags, return them with the requester ID.
module alu_share_arbiter
  import alu_arb_pkg::*;
#(
  parameter int WIDTH         = 64,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_ctrl,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_ctrl,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_negative,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  input  logic             alu_carry_out,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_result,
  output logic [3:0]       resp_flags,
  output logic             resp_err
);

  localparam int             CW       = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0]  LAST_CNT = CW'(SETTLE_CYCLES - 1);

  arb_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] op_a_q, op_b_q;
  logic [2:0]       op_ctrl_q;
  logic             resp_id_q, resp_err_q;
  logic [WIDTH-1:0] resp_result_q;
  logic [3:0]       resp_flags_q;

  logic [1:0]       grant_s;
  logic             accept_s, capture_s, legal_s;
  logic [WIDTH-1:0] sel_a_s, sel_b_s;
  logic [2:0]       sel_ctrl_s;
  logic [3:0]       alu_flags_s;

  alu_arb_pick u_pick (
    .clk_i       (clk),
    .reset_i     (reset),
    .req_valid_i ({req1_valid, req0_valid}),
    .accept_i    (accept_s),
    .grant_o     (grant_s)
  );

  // Winner's operands, acceptance and capture strobes.
  always_comb begin
    sel_a_s    = grant_s[1] ? req1_a    : req0_a;
    sel_b_s    = grant_s[1] ? req1_b    : req0_b;
    sel_ctrl_s = grant_s[1] ? req1_ctrl : req0_ctrl;
    legal_s    = ctrl_is_legal(sel_ctrl_s);
    accept_s   = (state_q == ST_IDLE) && (grant_s != 2'b00) && !reset;
    capture_s  = (state_q == ST_BUSY) && (cnt_q == LAST_CNT);
    alu_flags_s            = 4'b0000;
    alu_flags_s[FLAG_NEG]  = alu_negative;
    alu_flags_s[FLAG_ZERO] = alu_zero;
    alu_flags_s[FLAG_OVF]  = alu_overflow;
    alu_flags_s[FLAG_COUT] = alu_carry_out;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; illegal op codes skip the ALU entirely.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = legal_s ? ST_BUSY : ST_RESP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (capture_s) begin
          state_d = ST_RESP;
        end else begin
          state_d = ST_BUSY;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    req0_ready = accept_s & grant_s[0];
    req1_ready = accept_s & grant_s[1];
    resp_valid = (state_q == ST_RESP);
  end

  // Operand latch, settle counter and response capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q         <= {CW{1'b0}};
      op_a_q        <= {WIDTH{1'b0}};
      op_b_q        <= {WIDTH{1'b0}};
      op_ctrl_q     <= 3'b000;
      resp_id_q     <= 1'b0;
      resp_result_q <= {WIDTH{1'b0}};
      resp_flags_q  <= 4'b0000;
      resp_err_q    <= 1'b0;
    end else begin
      if (accept_s) begin
        cnt_q     <= {CW{1'b0}};
        resp_id_q <= grant_s[1];
      end else if (state_q == ST_BUSY) begin
        cnt_q <= cnt_q + CW'(1);
      end
      // The ALU bus keeps its previous operation when an illegal op is accepted.
      if (accept_s && legal_s) begin
        op_a_q    <= sel_a_s;
        op_b_q    <= sel_b_s;
        op_ctrl_q <= sel_ctrl_s;
      end
      if (accept_s && !legal_s) begin
        resp_result_q <= {WIDTH{1'b0}};
        resp_flags_q  <= 4'b0000;
        resp_err_q    <= 1'b1;
      end else if (capture_s) begin
        resp_result_q <= alu_result;
        resp_flags_q  <= alu_flags_s;
        resp_err_q    <= 1'b0;
      end
    end
  end

  assign alu_a       = op_a_q;
  assign alu_b       = op_b_q;
  assign alu_ctrl    = op_ctrl_q;
  assign resp_id     = resp_id_q;
  assign resp_result = resp_result_q;
  assign resp_flags  = resp_flags_q;
  assign resp_err    = resp_err_q;

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Sequencer and arbiter sharing the single structural 64-bit ALU (with NOR-tree zero flag) between two requesters, e.g. the datapath execute stage and the test/debug port. It accepts one operation at a time over a valid/ready handshake, holds operands stable on the ALU for a fixed gate-settle window, captures result and flags into registers, and returns them with the requester ID over a valid/ready response channel.

## Interface
- WIDTH, 64, operand/result width
- SETTLE_CYCLES, 4, cycles operands are held on the ALU before capture (legal ≥1)
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- req0_valid / req1_valid  in  1  request pending
- req0_ready / req1_ready  out  1  request accepted this cycle
- req0_a, req0_b / req1_a, req1_b  in  WIDTH  operands
- req0_ctrl / req1_ctrl  in  3  ALU op code
- alu_a, alu_b  out  WIDTH  operands to shared ALU
- alu_ctrl  out  3  op to shared ALU
- alu_result  in  WIDTH  ALU result
- alu_negative, alu_zero, alu_overflow, alu_carry_out  in  1  ALU flags
- resp_valid  out  1  response available
- resp_ready  in  1  consumer takes response
- resp_id  out  1  requester that issued the op
- resp_result  out  WIDTH  captured result
- resp_flags  out  4  {negative, zero, overflow, carry_out}
- resp_err  out  1  illegal op code

## Operation
- States: IDLE, BUSY, RESP.
- IDLE: grant one valid requester; reqN_ready=1 combinationally for the granted requester only; latch operands/ctrl/ID; go BUSY with counter=0. No valid → stay IDLE, all ready=0.
- Arbitration: one valid → that one wins. Both valid → requester not granted last wins (round-robin); last-grant register resets to 1, so requester 0 wins the first tie.
- Legal ctrl: 000 pass B, 010 add, 011 sub, 100 and, 101 or, 110 xor. Illegal (001, 111): accepted normally, ALU bypassed, go directly to RESP with resp_result=0, resp_flags=0, resp_err=1.
- BUSY: alu_a/alu_b/alu_ctrl driven from latched registers; counter increments each cycle; at counter==SETTLE_CYCLES-1 capture alu_result and flags into response registers, go RESP.
- RESP: resp_valid=1, outputs stable until resp_valid&resp_ready; then IDLE. No request accepted in BUSY or RESP (ready=0).
- Requester may drop valid without being granted; no state is affected.
- Counter width $clog2(SETTLE_CYCLES+1); no wrap within one operation.

## Timing
- Reset values: all ready=0, alu_a=alu_b=0, alu_ctrl=000, resp_valid=0, resp_id=0, resp_result=0, resp_flags=0, resp_err=0, state IDLE.
- Accept at cycle T → ALU driven from T+1 → capture at edge ending cycle T+SETTLE_CYCLES → resp_valid high from T+SETTLE_CYCLES+1.
- Illegal op: accept at T → resp_valid at T+1.
- Response handshake at cycle R → IDLE at R+1 → next accept at R+1 earliest.
- Reset asserted in any state: at next edge return to IDLE, in-flight op discarded, resp_valid drops, no response emitted.

## Configuration
- ALU_ARB_FIXED_PRIO_EN defined: requester 0 always wins ties; last-grant register omitted.
- Undefined: round-robin as above.

## Structure
- Package alu_arb_pkg: ctrl code constants (ALU_PASS_B, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR), state enum, flag bit indices (FLAG_NEG=3, FLAG_ZERO=2, FLAG_OVF=1, FLAG_COUT=0).
- Sub-module alu_arb_pick: grant logic (valids, last grant → grant vector), holds the macro-dependent logic.

## Test plan
- Single op: req0 add a=5, b=3 at cycle 0 → req0_ready at 0, resp_valid at 5, resp_result=8, flags=0000, resp_id=0.
- Tie: both valid from reset, both held → grants 0,1,0,1; with ALU_ARB_FIXED_PRIO_EN → 0,0,0 while req0 stays valid.
- Zero/flags: req1 sub a=7, b=7 → resp_result=0, resp_flags=0100; sub a=0, b=1 → result all ones, negative set.
- Backpressure: resp_ready=0 for 6 cycles → resp_valid and payload stable, both ready=0 throughout; release → IDLE next cycle.
- Illegal ctrl 111 on req0 → resp_valid one cycle after accept, resp_err=1, result=0, alu_ctrl unchanged.
- Reset at BUSY cycle 2 → next cycle state IDLE, resp_valid never asserts, outputs at reset values.
